// File: rtl/patp_mem_pkg.sv
// Shared types and constants for the PATP memory responder.
// Holds default widths, the wait-counter width and the FSM state encoding.
package patp_mem_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

endpackage

// File: rtl/patp_ram_array.sv
// 2**ADDR_W x DATA_W register store: synchronous write, synchronous clear,
// registered read port that holds its value between reads.
module patp_ram_array
   import patp_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic              ren,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (wen) mem[addr] <= wdata;
         if (ren) rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/patp_mem_responder.sv
// Memory-side responder for the MAR path: latches a request, waits
// WAIT_STATES cycles, performs the access and pulses ready for one cycle.
module patp_mem_responder
   import patp_mem_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_STATES = 1,
   parameter int PROT_TOP    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic              access;
   logic              prot_hit;

   // PROT_TOP=0 never matches since the address is unsigned.
   assign prot_hit = int'(addr_q) < PROT_TOP;

   always_comb begin
      state_nx = state;
      access   = 1'b0;
      case (state)
         S_IDLE: if (req) state_nx = S_WAIT;
         S_WAIT: begin
            if (cnt == '0) begin
               access   = 1'b1;
               state_nx = S_RESP;
            end
         end
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  we_q    <= we;
                  wdata_q <= wdata;
                  cnt     <= CNT_W'(WAIT_STATES);
                  err_q   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else           err_q <= we_q & prot_hit;
            end
            default: err_q <= 1'b0;
         endcase
      end
   end

   assign ready = (state == S_RESP);
   assign err   = ready & err_q;
   assign busy  = (state != S_IDLE);

   patp_ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .wen   (access & we_q & ~prot_hit),
      .ren   (access & ~we_q),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_patp_mem_responder.sv
// Directed bench for patp_mem_responder: three instances with different
// wait-state/protection settings, a transaction-level model and literal checks.
module tb_patp_mem_responder;

   localparam int WS_T [3] = '{1, 0, 3};
   localparam int PT_T [3] = '{0, 0, 8};

   logic       clk = 1'b0;
   logic       rst;
   logic       req   [3];
   logic       we    [3];
   logic [4:0] addr  [3];
   logic [7:0] wdata [3];
   logic [7:0] rdata [3];
   logic       ready [3];
   logic       err   [3];
   logic       busy  [3];

   int vectors = 0;
   int errs    = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   patp_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(1), .PROT_TOP(0)) u_d0 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
      .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0]));
   patp_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(0), .PROT_TOP(0)) u_d1 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
      .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1]));
   patp_mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_STATES(3), .PROT_TOP(8)) u_d2 (
      .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
      .rdata(rdata[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2]));

   // Transaction model: 'left' is the number of busy cycles still to come
   // for the transaction in flight (WS+1 waiting cycles plus one response).
   logic [7:0] m_mem [3][32];
   int         left  [3];
   logic [4:0] m_a   [3];
   logic       m_we  [3];
   logic [7:0] m_d   [3];
   logic       m_err [3];
   logic [7:0] m_rd  [3];

   initial for (int k = 0; k < 3; k++) left[k] = 0;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            left[k]  = 0;
            m_rd[k]  = 8'h00;
            m_err[k] = 1'b0;
            for (int j = 0; j < 32; j++) m_mem[k][j] = 8'h00;
         end else if (left[k] == 0) begin
            if (req[k]) begin
               m_a[k]   = addr[k];
               m_we[k]  = we[k];
               m_d[k]   = wdata[k];
               m_err[k] = 1'b0;
               left[k]  = WS_T[k] + 2;
            end
         end else begin
            left[k] = left[k] - 1;
            if (left[k] == 1) begin
               if (!m_we[k])                    m_rd[k] = m_mem[k][m_a[k]];
               else if (int'(m_a[k]) < PT_T[k]) m_err[k] = 1'b1;
               else                             m_mem[k][m_a[k]] = m_d[k];
            end
         end
      end
   end

   task automatic chk(input string name, input int k, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s[%0d] got %0h want %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk("busy",  k, int'(busy[k]),  int'(left[k] != 0));
            chk("ready", k, int'(ready[k]), int'(left[k] == 1));
            chk("err",   k, int'(err[k]),   int'(left[k] == 1 && m_err[k]));
            chk("rdata", k, int'(rdata[k]), int'(m_rd[k]));
         end
      end
   end

   // Issue one request, scramble the inputs after acceptance, wait for ready.
   task automatic xact(input int k, input logic w, input logic [4:0] a,
                       input logic [7:0] d, output int lat);
      @(negedge clk);
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            req[k] = 1'b0; we[k] = ~w; addr[k] = ~a; wdata[k] = ~d;
         end
      end while (!ready[k] && lat < 20);
      chk("xact_ready", k, int'(ready[k]), 1);
   endtask

   int lat, pulses;

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_busy",  k, int'(busy[k]),  0);
         chk("rst_rdata", k, int'(rdata[k]), 0);
      end

      // 1: read after reset, WS=1
      xact(0, 1'b0, 5'd7, 8'h00, lat);
      chk("t1_lat", 0, lat, 3);
      chk("t1_rdata", 0, int'(rdata[0]), 8'h00);

      // 2: write 31 then read back
      xact(0, 1'b1, 5'd31, 8'hA5, lat);
      chk("t2_wr_rdata", 0, int'(rdata[0]), 8'h00);
      chk("t2_wr_err", 0, int'(err[0]), 0);
      xact(0, 1'b0, 5'd31, 8'h00, lat);
      chk("t2_rd_rdata", 0, int'(rdata[0]), 8'hA5);
      chk("t2_rd_err", 0, int'(err[0]), 0);

      // 3: zero wait states
      xact(1, 1'b1, 5'd3, 8'h3C, lat);
      chk("t3_wr_lat", 1, lat, 2);
      xact(1, 1'b0, 5'd3, 8'h00, lat);
      chk("t3_rd_lat", 1, lat, 2);
      chk("t3_rdata", 1, int'(rdata[1]), 8'h3C);

      // 4: req held high; accepts only from IDLE (edges E0, E4, E8)
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'd1;
      pulses = 0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clk);
         if (j == 1) addr[0] = 5'd2;
         if (ready[0]) begin
            pulses++;
            if (pulses == 1) chk("t4_first", 0, j, 3);
            if (pulses == 2) chk("t4_second", 0, j, 7);
         end
      end
      req[0] = 1'b0;
      chk("t4_pulses", 0, pulses, 3);

      // 5: write protection below 8, WS=3
      xact(2, 1'b1, 5'd4, 8'hFF, lat);
      chk("t5_lat", 2, lat, 5);
      chk("t5_err", 2, int'(err[2]), 1);
      xact(2, 1'b0, 5'd4, 8'h00, lat);
      chk("t5_rd4", 2, int'(rdata[2]), 8'h00);
      chk("t5_rd_err", 2, int'(err[2]), 0);
      xact(2, 1'b1, 5'd8, 8'hAB, lat);
      chk("t5_err8", 2, int'(err[2]), 0);
      xact(2, 1'b0, 5'd8, 8'h00, lat);
      chk("t5_rd8", 2, int'(rdata[2]), 8'hAB);

      // 6: reset in the second WAIT cycle of a write
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 5'd10; wdata[2] = 8'h55;
      @(negedge clk);
      req[2] = 1'b0;
      @(negedge clk);
      chk("t6_busy_pre", 2, int'(busy[2]), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_busy_post", 2, int'(busy[2]), 0);
      pulses = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (ready[2]) pulses++;
      end
      chk("t6_no_ready", 2, pulses, 0);
      xact(2, 1'b0, 5'd10, 8'h00, lat);
      chk("t6_rd10", 2, int'(rdata[2]), 8'h00);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
